// File: rtl/uart_pkg.sv
// Shared types and frame constants for the console UART receive path.
package uart_pkg;

   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_BREAK
   } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with a registered head output.
// Occupancy drives full/empty; pointers wrap naturally because DEPTH is a power of two.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    rd_next;
   logic             do_push;
   logic             do_pop;
   logic             old_left;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rd_next = do_pop ? rd_ptr + AW'(1) : rd_ptr;
   // True when an entry already stored becomes (or stays) the head after this edge.
   assign old_left = (count > CW'(1)) || ((count == CW'(1)) && !do_pop);

   always_ff @(posedge i_clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         rdata  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         rd_ptr <= rd_next;
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (old_left) begin
            rdata <= mem[rd_next];
         end else if (do_push) begin
            rdata <= wdata;
         end
      end
   end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 console receiver: synchronizer, mid-bit sampling FSM and FWFT byte FIFO.
// Flags framing errors and bytes dropped on a full FIFO.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | line high, waiting for a falling start edge
// ST_START | counting to mid start bit; high there means a glitch
// ST_DATA  | sampling 8 data bits LSB first, one per bit period
// ST_STOP  | sampling stop bit; high pushes the byte, low is a frame error
// ST_BREAK | line held low after a frame error, waiting for it to release
module uart_receiver
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 347,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic                            i_uart_rx,
   output logic [7:0]                      o_data,
   output logic                            o_valid,
   input  logic                            i_ready,
   output logic                            o_frame_err,
   output logic                            o_overrun,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] o_count
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT/2 - 1);

   rx_state_t            state;
   logic [CNT_W-1:0]     cnt;
   logic [IDX_W-1:0]     bit_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 rx_meta;
   logic                 rx_s;
   logic                 stop_ok;
   logic                 pop_req;
   logic                 fifo_full;
   logic                 fifo_empty;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= i_uart_rx;
         rx_s    <= rx_meta;
      end
   end

   // Push is taken combinationally so the byte lands on the stop-sample edge itself.
   assign stop_ok = (state == ST_STOP) && (cnt == '0) && rx_s;
   assign pop_req = i_ready && !fifo_empty;
   assign o_valid = !fifo_empty;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         bit_idx     <= '0;
         shreg       <= '0;
         o_frame_err <= 1'b0;
         o_overrun   <= 1'b0;
      end else begin
         o_frame_err <= 1'b0;
         o_overrun   <= stop_ok && fifo_full && !pop_req;
         case (state)
            ST_IDLE: begin
               if (!rx_s) begin
                  cnt   <= CNT_HALF;
                  state <= ST_START;
               end
            end
            ST_START: begin
               if (cnt == '0) begin
                  if (rx_s) begin
                     state <= ST_IDLE;
                  end else begin
                     cnt     <= CNT_FULL;
                     bit_idx <= '0;
                     state   <= ST_DATA;
                  end
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            ST_DATA: begin
               if (cnt == '0) begin
                  shreg[bit_idx] <= rx_s;
                  cnt            <= CNT_FULL;
                  if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                     state <= ST_STOP;
                  end else begin
                     bit_idx <= bit_idx + IDX_W'(1);
                  end
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            ST_STOP: begin
               if (cnt == '0) begin
                  if (rx_s) begin
                     state <= ST_IDLE;
                  end else begin
                     o_frame_err <= 1'b1;
                     state       <= ST_BREAK;
                  end
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            ST_BREAK: begin
               if (rx_s) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .push  (stop_ok),
      .wdata (shreg),
      .pop   (pop_req),
      .rdata (o_data),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (o_count)
   );

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Asynchronous serial receiver for the SoC console port: turns the `i_uart_rx` pin stream (8N1, LSB first) into bytes in a small first-word-fall-through FIFO. It is read through a valid/ready handshake by the SoC's UART register block. It is the receive-side counterpart of the existing UART transmitter and runs in the PLL output clock domain. The block flags framing errors and overruns.

## Interface
- `CLKS_PER_BIT`, 347, clock cycles per bit period (40 MHz / 115200); must be ≥ 4.
- `FIFO_DEPTH`, 16, receive FIFO entries; must be a power of two, ≥ 2.

- `i_clk`  in  1  system clock (PLL output).
- `i_rst`  in  1  synchronous, active-high reset.
- `i_uart_rx`  in  1  serial input, asynchronous to `i_clk`, idle high.
- `o_data`  out  8  FIFO head byte; valid while `o_valid`.
- `o_valid`  out  1  FIFO not empty.
- `i_ready`  in  1  consumer accepts the head byte when `o_valid && i_ready`.
- `o_frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `o_overrun`  out  1  one-cycle pulse: completed byte dropped because the FIFO was full.
- `o_count`  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.

## Operation
- Input path: 2-flop synchronizer. Both flops reset to 1. All decisions use the synchronized signal `rx_s`.
- State machine: IDLE, START, DATA, STOP, BREAK.
  - IDLE: when `rx_s==0`, load `cnt = CLKS_PER_BIT/2 - 1` and go to START.
  - START: decrement `cnt`. At `cnt==0`, sample `rx_s`:
    - 1 → glitch; go to IDLE with no output.
    - 0 → load `cnt = CLKS_PER_BIT-1`, `bit_idx=0`, go to DATA.
  - DATA: at each `cnt==0`, shift `rx_s` into bit `bit_idx` (LSB first) and reload `cnt`. After bit 7, go to STOP.
  - STOP: at `cnt==0`, sample `rx_s`:
    - 1 → push the byte and go to IDLE on the same edge, so a new start bit can be detected from the next cycle.
    - 0 → pulse `o_frame_err`, discard the byte, go to BREAK.
  - BREAK: wait for `rx_s==1`, then go to IDLE. A held-low line therefore yields exactly one frame error.
- FIFO push rule: a push is accepted if the FIFO is not full, or if a pop happens in the same cycle. Otherwise pulse `o_overrun` and drop the byte; FIFO contents are unchanged.
- Pop: occurs on `o_valid && i_ready`. `i_ready` while empty has no effect.
- Simultaneous push and pop: `o_count` is unchanged and ordering is preserved.
- Read and write pointers wrap modulo `FIFO_DEPTH`. Full and empty are decided from `o_count`.
- Reset values:
  - FIFO empty, `o_valid=0`, `o_count=0`.
  - `o_frame_err=0`, `o_overrun=0`.
  - `o_data=0`.
  - State IDLE, synchronizer `1,1`.
- Reset mid-frame aborts the frame; nothing is pushed. After reset, a line still low is treated as a start bit only once `rx_s` is seen low in IDLE.

## Timing
- Let T be the first cycle with `rx_s==0` in IDLE. This is 2 cycles after the pin falls, ±1 for asynchronous phase.
- Sample points:
  - start: T + `CLKS_PER_BIT/2`.
  - data bit k: T + `CLKS_PER_BIT/2` + (k+1)·`CLKS_PER_BIT`.
  - stop: T + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT`.
- Push happens at the stop-sample edge. `o_valid` and `o_data` update on the following cycle.
- `o_frame_err` and `o_overrun` are registered and high for exactly the one cycle after the stop sample.
- `o_data` is registered from the FIFO head. After a pop, the next entry appears on the following cycle, so back-to-back pops run at 1 byte/cycle.
- Throughput: one byte every 10 bit periods. Integer `CLKS_PER_BIT` tolerates about ±4% baud mismatch.

## Structure
- Package `uart_pkg`: state enum (IDLE/START/DATA/STOP/BREAK) and the frame constants (`DATA_BITS=8`, `STOP_BITS=1`).
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH; push/pop/full/empty/count, FWFT), reused later for the TX side.
- Baud counter, synchronizer and FSM stay in `uart_receiver`.

## Test plan
Benches run with `CLKS_PER_BIT=8` and `FIFO_DEPTH=4`.
- Single byte: frame 0xA5, `i_ready=0` → `o_valid` rises at T+77, `o_data=0xA5`, `o_count=1`. Raising `i_ready` for one cycle → `o_valid=0`, `o_count=0`.
- Glitch: pin low for 3 cycles, then high → no push and no error; FSM back in IDLE. A following frame 0x3C is received correctly.
- Framing error: frame 0x55 with stop bit 0 and the line held low for 40 cycles → one `o_frame_err` pulse, `o_count=0`. The next valid frame 0x01 is received.
- Overrun: 5 back-to-back frames 0x10..0x14 with `i_ready=0` → `o_count=4`, one `o_overrun` pulse on the 5th, FIFO holds 0x10..0x13. Draining returns them in order.
- Push and pop while full: FIFO full, `i_ready=1` held high across the 5th stop-bit sample → `o_overrun` stays 0 and the bytes drain in order 0x10..0x14. `o_count` equals 4 (unchanged) on the push/pop cycle, then decreases by 1 per cycle to 0.
- Reset mid-frame: assert `i_rst` during DATA bit 4 → all outputs return to reset values and no byte is pushed. The next full frame 0xFF is received correctly.
